systolic_ctrl_4x4: RTL and testbench

SYSTOLIC_CTRL_4X4 -- requirements
Module: systolic_ctrl_4x4

---
 rtl/systolic_ctrl_4x4.sv | 162 ++++++++++++++++
 tb/tb_systolic_ctrl_4x4.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_ctrl_4x4.sv
// Controller for a 4x4 systolic array: latches A/B on accept, clears the array, streams
// skewed row/column feeds, then waits (bounded) for the array and hands back its result.
module systolic_ctrl_4x4 #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned FRAC_WIDTH = 8,
    parameter int unsigned TIMEOUT    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_valid,
    output logic                   start_ready,
    input  logic [16*WIDTH-1:0]    a_mat,
    input  logic [16*WIDTH-1:0]    b_mat,
    output logic                   arr_rst_n,
    output logic [WIDTH-1:0]       arr_west0,
    output logic [WIDTH-1:0]       arr_west4,
    output logic [WIDTH-1:0]       arr_west8,
    output logic [WIDTH-1:0]       arr_west12,
    output logic [WIDTH-1:0]       arr_north0,
    output logic [WIDTH-1:0]       arr_north1,
    output logic [WIDTH-1:0]       arr_north2,
    output logic [WIDTH-1:0]       arr_north3,
    input  logic                   arr_done,
    input  logic [WIDTH*WIDTH-1:0] arr_out,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [WIDTH*WIDTH-1:0] result,
    output logic                   err,
    output logic                   busy
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    // The fixed-point format is only carried through; reject a nonsensical split early.
    if (FRAC_WIDTH >= WIDTH) begin : g_bad_frac
        $error("FRAC_WIDTH must be smaller than WIDTH");
    end

    typedef enum logic [2:0] {StIdle, StClear, StFeed, StDrain, StDone} state_e;

    state_e                 state_q, state_d;
    logic [2:0]             t_q, t_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [16*WIDTH-1:0]    a_q, a_d, b_q, b_d;
    logic [WIDTH*WIDTH-1:0] result_d;
    logic                   err_d;
    logic [WIDTH-1:0]       west_d [4];
    logic [WIDTH-1:0]       north_d [4];

    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result;
        err_d    = err;
        unique case (state_q)
            StIdle: begin
                if (start_valid && start_ready) begin
                    a_d     = a_mat;
                    b_d     = b_mat;
                    state_d = StClear;
                end
            end
            StClear: begin
                t_d     = 3'd0;
                state_d = StFeed;
            end
            StFeed: begin
                if (t_q == 3'd6) begin
                    cnt_d   = '0;
                    state_d = StDrain;
                end else begin
                    t_d = t_q + 3'd1;
                end
            end
            StDrain: begin
                if (arr_done) begin
                    result_d = arr_out;
                    err_d    = 1'b0;
                    state_d  = StDone;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    result_d = arr_out;
                    err_d    = 1'b1;
                    state_d  = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Feeds are computed for the upcoming cycle so they leave the design registered.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            west_d[i]  = '0;
            north_d[i] = '0;
        end
        if (state_d == StFeed) begin
            for (int i = 0; i < 4; i++) begin
                for (int k = 0; k < 4; k++) begin
                    if (int'(t_d) == i + 3 - k) begin
                        west_d[i]  = a_q[(i*4+k)*WIDTH +: WIDTH];
                        north_d[i] = b_q[(k*4+i)*WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            t_q         <= '0;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result      <= '0;
            err         <= 1'b0;
            res_valid   <= 1'b0;
            busy        <= 1'b0;
            start_ready <= 1'b0;
            arr_rst_n   <= 1'b0;
            arr_west0   <= '0;
            arr_west4   <= '0;
            arr_west8   <= '0;
            arr_west12  <= '0;
            arr_north0  <= '0;
            arr_north1  <= '0;
            arr_north2  <= '0;
            arr_north3  <= '0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result      <= result_d;
            err         <= err_d;
            res_valid   <= (state_d == StDone);
            busy        <= (state_d == StClear) || (state_d == StFeed) || (state_d == StDrain);
            start_ready <= (state_d == StIdle);
            arr_rst_n   <= (state_d != StClear);
            arr_west0   <= west_d[0];
            arr_west4   <= west_d[1];
            arr_west8   <= west_d[2];
            arr_west12  <= west_d[3];
            arr_north0  <= north_d[0];
            arr_north1  <= north_d[1];
            arr_north2  <= north_d[2];
            arr_north3  <= north_d[3];
        end
    end

endmodule

// File: tb/tb_systolic_ctrl_4x4.sv
// Bench for systolic_ctrl_4x4: a behavioural 4x4 array fed by the DUT, a timeline model
// of the controller, per-cycle comparison, and directed jobs with literal expectations.
module tb_systolic_ctrl_4x4;

    localparam int W  = 16;
    localparam int TO = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start_valid;
    logic           start_ready;
    logic [16*W-1:0] a_mat, b_mat;
    logic           arr_rst_n;
    logic [W-1:0]   arr_west0, arr_west4, arr_west8, arr_west12;
    logic [W-1:0]   arr_north0, arr_north1, arr_north2, arr_north3;
    logic           arr_done;
    logic [W*W-1:0] arr_out;
    logic           res_valid, res_ready, err, busy;
    logic [W*W-1:0] result;

    always #5 clk = ~clk;

    systolic_ctrl_4x4 #(.WIDTH(W), .FRAC_WIDTH(8), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
        .a_mat(a_mat), .b_mat(b_mat), .arr_rst_n(arr_rst_n),
        .arr_west0(arr_west0), .arr_west4(arr_west4), .arr_west8(arr_west8),
        .arr_west12(arr_west12), .arr_north0(arr_north0), .arr_north1(arr_north1),
        .arr_north2(arr_north2), .arr_north3(arr_north3), .arr_done(arr_done),
        .arr_out(arr_out), .res_valid(res_valid), .res_ready(res_ready), .result(result),
        .err(err), .busy(busy)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    int a1 [16] = '{2, 1, 2, 1,  0, 1, 0, 1,  1, 2, 0, 1,  1, 1, 1, 0};
    int b1 [16] = '{0, 1, 4, 3,  3, 0, 1, 0,  1, 4, 1, 2,  3, 0, 2, 0};
    int c1 [16] = '{8, 10, 13, 10,  6, 0, 3, 0,  9, 1, 8, 3,  4, 5, 6, 5};
    int a2 [16] = '{-1, 2, 0, 3,  1, -2, 1, 0,  0, 0, -3, 1,  2, 1, 1, -1};
    int b2 [16] = '{1, 0, -1, 2,  0, 3, 1, -1,  -2, 1, 0, 1,  1, -1, 2, 0};
    int id4 [16] = '{1, 0, 0, 0,  0, 1, 0, 0,  0, 0, 1, 0,  0, 0, 0, 1};
    int w0_exp [7] = '{'h100, 'h200, 'h100, 'h200, 0, 0, 0};
    int n3_exp [7] = '{0, 0, 0, 0, 'h200, 0, 'h300};

    function automatic logic [255:0] pack_q(input int m [16]);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[i*16 +: 16] = 16'(m[i] * 256);
        return r;
    endfunction

    // Q8.8 matrix product of the two packed 4x4 operands.
    function automatic logic [255:0] qmul(input logic [255:0] a, input logic [255:0] b);
        logic [255:0] r;
        longint s;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = 0;
                for (int k = 0; k < 4; k++)
                    s += longint'($signed(a[(i*4+k)*16 +: 16])) *
                         longint'($signed(b[(k*4+j)*16 +: 16]));
                r[(i*4+j)*16 +: 16] = 16'(s >>> 8);
            end
        end
        return r;
    endfunction

    // Behavioural array: PE(i,j) sees row i delayed j cycles and column j delayed i cycles.
    logic signed [15:0] wh [4][64];
    logic signed [15:0] nh [4][64];
    int  acnt = 0;
    bit  done_en;

    always @(posedge clk) begin
        if (!arr_rst_n) begin
            acnt <= 0;
        end else if (acnt < 64) begin
            wh[0][acnt] <= arr_west0;   wh[1][acnt] <= arr_west4;
            wh[2][acnt] <= arr_west8;   wh[3][acnt] <= arr_west12;
            nh[0][acnt] <= arr_north0;  nh[1][acnt] <= arr_north1;
            nh[2][acnt] <= arr_north2;  nh[3][acnt] <= arr_north3;
            acnt <= acnt + 1;
        end
    end

    always_comb begin
        longint s;
        arr_out = '0;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = 0;
                for (int c = 0; c < 64; c++)
                    if (c < acnt && c >= i && c >= j)
                        s += longint'(wh[i][c-j]) * longint'(nh[j][c-i]);
                arr_out[(i*4+j)*W +: W] = W'(s >>> 8);
            end
        end
    end

    assign arr_done = done_en && (acnt >= 13);

    // Controller timeline: m_age counts cycles since accept (0 = clear, 1..7 = feed t=age-1,
    // 8.. = drain); m_done marks a result on offer.
    bit           m_rst  = 1'b1;
    bit           m_done = 1'b0;
    bit           m_err  = 1'b0;
    int           m_age  = -1;
    logic [255:0] m_a, m_b;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_rst = 1'b1; m_done = 1'b0; m_err = 1'b0; m_age = -1;
        end else if (m_rst) begin
            m_rst = 1'b0;
        end else if (m_done) begin
            if (res_ready) m_done = 1'b0;
        end else if (m_age < 0) begin
            if (start_valid) begin
                m_age = 0; m_a = a_mat; m_b = b_mat;
            end
        end else if (m_age >= 8 && (arr_done || m_age - 8 == TO - 1)) begin
            m_done = 1'b1; m_err = !arr_done; m_age = -1;
        end else begin
            m_age++;
        end
    end

    initial forever begin
        logic e_sr, e_ar, e_busy, e_rv;
        logic [15:0] ew [4];
        logic [15:0] en [4];
        logic [15:0] aw [4];
        logic [15:0] an [4];
        int t, d;
        @(negedge clk);
        e_sr = 0; e_ar = 0; e_busy = 0; e_rv = 0;
        for (int i = 0; i < 4; i++) begin ew[i] = '0; en[i] = '0; end
        if (!m_rst) begin
            e_ar = 1;
            if (m_done) e_rv = 1;
            else if (m_age < 0) e_sr = 1;
            else begin
                e_busy = 1;
                if (m_age == 0) e_ar = 0;
                else if (m_age <= 7) begin
                    t = m_age - 1;
                    for (int i = 0; i < 4; i++) begin
                        d = t - i;
                        if (d >= 0 && d <= 3) begin
                            ew[i] = m_a[(i*4 + 3 - d)*16 +: 16];
                            en[i] = m_b[((3 - d)*4 + i)*16 +: 16];
                        end
                    end
                end
            end
        end
        aw[0] = arr_west0;  aw[1] = arr_west4;  aw[2] = arr_west8;  aw[3] = arr_west12;
        an[0] = arr_north0; an[1] = arr_north1; an[2] = arr_north2; an[3] = arr_north3;
        chk("start_ready", start_ready, e_sr);
        chk("arr_rst_n", arr_rst_n, e_ar);
        chk("busy", busy, e_busy);
        chk("res_valid", res_valid, e_rv);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("west%0d", i*4), aw[i], ew[i]);
            chk($sformatf("north%0d", i), an[i], en[i]);
        end
        if (m_done) begin
            chk("result", result, qmul(m_a, m_b));
            chk("err", err, m_err);
        end
    end

    int lowcnt = 0;
    initial forever begin
        @(negedge clk);
        if (rst_n && !arr_rst_n) lowcnt++;
    end

    task automatic start_job(input logic [255:0] a, input logic [255:0] b);
        chk("accept_ready", start_ready, 1'b1);
        a_mat = a; b_mat = b; start_valid = 1'b1;
        @(negedge clk);
        // Scramble the inputs: the running job must use the latched copies.
        start_valid = 1'b0; a_mat = ~a; b_mat = {b[127:0], b[255:128]};
    endtask

    task automatic wait_res(input int max, output int n);
        n = 0;
        while (!res_valid && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("res_valid_wait", res_valid, 1'b1);
    endtask

    task automatic finish_res();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("idle_res_valid", res_valid, 1'b0);
        chk("idle_start_ready", start_ready, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b0; done_en = 1'b1;
        a_mat = '0; b_mat = '0;
        repeat (3) @(negedge clk);
        chk("rst_start_ready", start_ready, 1'b0);
        chk("rst_arr_rst_n", arr_rst_n, 1'b0);
        chk("rst_result", result, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", start_ready, 1'b1);
        chk("post_rst_arr_rst_n", arr_rst_n, 1'b1);

        // Basic job with feed-skew literals.
        start_job(pack_q(a1), pack_q(b1));
        chk("clear_arr_rst_n", arr_rst_n, 1'b0);
        for (int t = 0; t < 7; t++) begin
            @(negedge clk);
            chk($sformatf("skew_west0_t%0d", t), arr_west0, 16'(w0_exp[t]));
            chk($sformatf("skew_north3_t%0d", t), arr_north3, 16'(n3_exp[t]));
        end
        wait_res(80, n);
        chk("basic_result", result, pack_q(c1));
        chk("basic_err", err, 1'b0);
        finish_res();

        // Array never reports done: drain must time out.
        done_en = 1'b0;
        start_job(pack_q(a1), pack_q(b1));
        wait_res(100, n);
        chk("timeout_latency", n, 40);
        chk("timeout_err", err, 1'b1);
        chk("timeout_result", result, pack_q(c1));
        finish_res();
        done_en = 1'b1;

        // Backpressure, start pulses while a result is pending, and a DONE-cycle start.
        start_job(pack_q(a2), pack_q(b2));
        wait_res(80, n);
        for (int c = 0; c < 10; c++) begin
            start_valid = c[0];
            @(negedge clk);
            chk("bp_start_ready", start_ready, 1'b0);
            chk("bp_res_valid", res_valid, 1'b1);
        end
        res_ready = 1'b1; start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0; res_ready = 1'b0;
        chk("bp_release_valid", res_valid, 1'b0);
        chk("bp_release_busy", busy, 1'b0);
        chk("bp_release_ready", start_ready, 1'b1);
        @(negedge clk);
        chk("bp_no_accept", busy, 1'b0);

        // Reset in the middle of FEED at t=3.
        start_job(pack_q(a1), pack_q(b1));
        repeat (4) @(negedge clk);
        chk("mid_feed_west0", arr_west0, 16'h0200);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_arr_rst_n", arr_rst_n, 1'b0);
        chk("mid_rst_west", {arr_west0, arr_west4, arr_west8, arr_west12}, '0);
        chk("mid_rst_north", {arr_north0, arr_north1, arr_north2, arr_north3}, '0);
        chk("mid_rst_busy", busy, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_no_valid", res_valid, 1'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        start_job(pack_q(a1), pack_q(b1));
        wait_res(80, n);
        chk("after_rst_result", result, pack_q(c1));
        finish_res();

        // Back-to-back: second job accepted in the first IDLE cycle, A = identity.
        lowcnt = 0;
        start_job(pack_q(a1), pack_q(b1));
        wait_res(80, n);
        chk("b2b_first_result", result, pack_q(c1));
        chk("b2b_clear_cycles1", lowcnt, 1);
        res_ready = 1'b1; start_valid = 1'b1;
        a_mat = pack_q(id4); b_mat = pack_q(b1);
        @(negedge clk);
        res_ready = 1'b0;
        chk("b2b_idle_ready", start_ready, 1'b1);
        lowcnt = 0;
        @(negedge clk);
        start_valid = 1'b0;
        wait_res(80, n);
        chk("b2b_identity_result", result, pack_q(b1));
        chk("b2b_clear_cycles2", lowcnt, 1);
        finish_res();

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
